// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: MEM stage with a direct-mapped, write-through, no-write-allocate data cache.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
`default_nettype none

module mem_stage_dcache #(
    parameter int INDEX_W = 4,
    parameter int DATA_W  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] branchTarget,
    input  logic              zeroFlag,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] readData2,
    input  logic [4:0]        writeReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              RegWrite,
    input  logic              MemToReg,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branchTargetOut,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [4:0]        writeRegOut,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic              hitOut
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hitCount,
    output logic [31:0]       missCount
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = DATA_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WTHRU  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] txn_idx;
    logic [TAG_W-1:0]   txn_tag;
    logic               hit;
    logic               load_hit;
    logic               txn_start;

    assign idx      = ALUResult[INDEX_W+1:2];
    assign tag      = ALUResult[DATA_W-1:INDEX_W+2];
    // Refill writes use the latched request address, not the live pipeline inputs.
    assign txn_idx  = mem_addr[INDEX_W+1:2];
    assign txn_tag  = mem_addr[DATA_W-1:INDEX_W+2];
    assign hit      = valid[idx] && (tag_arr[idx] == tag);
    assign load_hit = (state == IDLE) && MemRead && !MemWrite && hit;

    assign pcSrc           = Branch & zeroFlag;
    assign branchTargetOut = branchTarget;

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = MemWrite | (MemRead & ~hit);
                if (MemWrite)
                    next_state = WTHRU;
                else if (MemRead && !hit)
                    next_state = REFILL;
            end
            REFILL, WTHRU: begin
                stall = ~mem_ack;
                if (mem_ack)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign txn_start = (state == IDLE) && (next_state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            valid        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            readDataOut  <= '0;
            ALUResultOut <= '0;
            writeRegOut  <= '0;
            RegWriteOut  <= 1'b0;
            MemToRegOut  <= 1'b0;
            hitOut       <= 1'b0;
        end else begin
            state   <= next_state;
            mem_req <= (next_state != IDLE);
            mem_we  <= (next_state == WTHRU);
            if (txn_start) begin
                mem_addr  <= {ALUResult[DATA_W-1:2], 2'b00};
                mem_wdata <= readData2;
            end
            if (state == REFILL && mem_ack)
                valid[txn_idx] <= 1'b1;
            if (!stall) begin
                readDataOut  <= (state == REFILL) ? mem_rdata : data_arr[idx];
                ALUResultOut <= ALUResult;
                writeRegOut  <= writeReg;
                RegWriteOut  <= RegWrite;
                MemToRegOut  <= MemToReg;
                hitOut       <= load_hit;
            end else begin
                RegWriteOut  <= 1'b0;
                MemToRegOut  <= 1'b0;
                hitOut       <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (state == REFILL && mem_ack) begin
            tag_arr[txn_idx]  <= txn_tag;
            data_arr[txn_idx] <= mem_rdata;
        end else if (state == IDLE && MemWrite && hit) begin
            data_arr[idx] <= readData2;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hitCount  <= '0;
            missCount <= '0;
        end else begin
            if (load_hit && hitCount != 32'hFFFF_FFFF)
                hitCount <= hitCount + 32'd1;
            if (state == IDLE && next_state == REFILL && missCount != 32'hFFFF_FFFF)
                missCount <= missCount + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_dcache.sv
// tb_mem_stage_dcache: directed self-checking bench for mem_stage_dcache.
`default_nettype none

module tb_mem_stage_dcache;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] branchTarget, ALUResult, readData2, mem_rdata;
    logic        zeroFlag, MemRead, MemWrite, Branch, RegWrite, MemToReg, mem_ack;
    logic [4:0]  writeReg;
    logic        pcSrc, stall, mem_req, mem_we;
    logic [31:0] branchTargetOut, mem_addr, mem_wdata, readDataOut, ALUResultOut;
    logic [4:0]  writeRegOut;
    logic        RegWriteOut, MemToRegOut, hitOut;
`ifdef DCACHE_STATS_EN
    logic [31:0] hitCount, missCount;
`endif

    int checks = 0;
    int errors = 0;
    int n_stall;

    always #5 CLK = ~CLK;

    mem_stage_dcache #(.INDEX_W(4), .DATA_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .branchTarget(branchTarget), .zeroFlag(zeroFlag), .ALUResult(ALUResult),
        .readData2(readData2), .writeReg(writeReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .pcSrc(pcSrc), .branchTargetOut(branchTargetOut), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .readDataOut(readDataOut), .ALUResultOut(ALUResultOut), .writeRegOut(writeRegOut),
        .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .hitOut(hitOut)
`ifdef DCACHE_STATS_EN
        , .hitCount(hitCount), .missCount(missCount)
`endif
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clear_inputs();
        branchTarget = '0; zeroFlag = 0; ALUResult = '0; readData2 = '0;
        writeReg = '0; MemRead = 0; MemWrite = 0; Branch = 0;
        RegWrite = 0; MemToReg = 0; mem_ack = 0; mem_rdata = '0;
    endtask

    // Called at a negedge with the request already driven (detect cycle).
    // Acks in transaction cycle ack_at; returns at posedge+1 after the ack edge.
    task automatic mem_txn(input string tag, input int ack_at, input logic [31:0] rdata,
                           input logic exp_we, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, output int ns);
        ns = 0;
        #1;
        if (stall) ns++;
        for (int c = 1; c <= 8; c++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (c == 1) begin
                check({tag, "_req"}, 32'(mem_req), 32'd1);
                check({tag, "_we"}, 32'(mem_we), 32'(exp_we));
                check({tag, "_addr"}, mem_addr, exp_addr);
                if (exp_we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
            end
            if (c == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            #1;
            if (stall) ns++;
            if (c == ack_at) break;
        end
        @(posedge CLK);
        #1;
        mem_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", readDataOut, 32'd0);
        check("rst_regwr", 32'(RegWriteOut), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Cold miss, ack in 3rd REFILL cycle
        @(negedge CLK);
        ALUResult = 32'h20; MemRead = 1; RegWrite = 1; MemToReg = 1; writeReg = 5'd5;
        mem_txn("miss1", 3, 32'hDEADBEEF, 1'b0, 32'h20, 32'h0, n_stall);
        check("miss1_stalls", n_stall, 3);
        check("miss1_rdata", readDataOut, 32'hDEADBEEF);
        check("miss1_hit", 32'(hitOut), 32'd0);
        check("miss1_regwr", 32'(RegWriteOut), 32'd1);
        check("miss1_memtoreg", 32'(MemToRegOut), 32'd1);
        check("miss1_wreg", 32'(writeRegOut), 32'd5);
        check("miss1_req_clr", 32'(mem_req), 32'd0);

        // Repeat load hits
        @(negedge CLK);
        #1;
        check("hit1_stall", 32'(stall), 32'd0);
        check("hit1_req", 32'(mem_req), 32'd0);
        @(posedge CLK);
        #1;
        check("hit1_rdata", readDataOut, 32'hDEADBEEF);
        check("hit1_hit", 32'(hitOut), 32'd1);
        check("hit1_req_after", 32'(mem_req), 32'd0);

        // Store hit updates line, write-through with ack in 1st cycle
        @(negedge CLK);
        MemRead = 0; MemWrite = 1; readData2 = 32'h3; RegWrite = 0; MemToReg = 0;
        mem_txn("st1", 1, 32'h0, 1'b1, 32'h20, 32'h3, n_stall);
        check("st1_stalls", n_stall, 1);
        check("st1_hit", 32'(hitOut), 32'd0);
        @(negedge CLK);
        MemWrite = 0; MemRead = 1; RegWrite = 1; MemToReg = 1;
        #1;
        check("hit2_stall", 32'(stall), 32'd0);
        @(posedge CLK);
        #1;
        check("hit2_rdata", readDataOut, 32'h3);
        check("hit2_hit", 32'(hitOut), 32'd1);

        // Conflict miss on index 8 evicts 0x20
        @(negedge CLK);
        ALUResult = 32'h60;
        mem_txn("miss2", 2, 32'h55, 1'b0, 32'h60, 32'h0, n_stall);
        check("miss2_stalls", n_stall, 2);
        check("miss2_rdata", readDataOut, 32'h55);
        check("miss2_hit", 32'(hitOut), 32'd0);
        @(negedge CLK);
        ALUResult = 32'h20;
        #1;
        check("evict_stall", 32'(stall), 32'd1);
        mem_txn("miss3", 1, 32'hDEADBEEF, 1'b0, 32'h20, 32'h0, n_stall);
        check("miss3_stalls", n_stall, 1);
        check("miss3_rdata", readDataOut, 32'hDEADBEEF);

        // Reset mid-REFILL
        @(negedge CLK);
        ALUResult = 32'h63;
        #1;
        check("rst2_detect", 32'(stall), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("rst2_req_before", 32'(mem_req), 32'd1);
        check("rst2_addr", mem_addr, 32'h60);
        #1;
        RST_N = 1'b0; MemRead = 0; RegWrite = 0; MemToReg = 0;
        #1;
        check("rst2_req", 32'(mem_req), 32'd0);
        check("rst2_stall", 32'(stall), 32'd0);
        check("rst2_rdata", readDataOut, 32'd0);
        check("rst2_aluout", ALUResultOut, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Stray ack in IDLE is ignored
        @(negedge CLK);
        mem_ack = 1; mem_rdata = 32'hBAD;
        @(posedge CLK);
        #1;
        check("stray_ack_req", 32'(mem_req), 32'd0);
        mem_ack = 0;

        // Valid bits cleared: 0x20 misses again
        @(negedge CLK);
        ALUResult = 32'h20; MemRead = 1; RegWrite = 1;
        mem_txn("miss4", 1, 32'h77, 1'b0, 32'h20, 32'h0, n_stall);
        check("miss4_stalls", n_stall, 1);
        check("miss4_rdata", readDataOut, 32'h77);

        // Non-memory passthrough
        @(negedge CLK);
        MemRead = 0; ALUResult = 32'h1234; RegWrite = 1; writeReg = 5'd9;
        @(posedge CLK);
        #1;
        check("alu_pass", ALUResultOut, 32'h1234);
        check("alu_wreg", 32'(writeRegOut), 32'd9);
        check("alu_hit", 32'(hitOut), 32'd0);

        // Branch resolution
        @(negedge CLK);
        Branch = 1; zeroFlag = 1; branchTarget = 32'h84;
        #1;
        check("br_taken", 32'(pcSrc), 32'd1);
        check("br_target", branchTargetOut, 32'h84);
        zeroFlag = 0;
        #1;
        check("br_not_taken", 32'(pcSrc), 32'd0);
        Branch = 0; zeroFlag = 1;
        #1;
        check("br_no_branch", 32'(pcSrc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
